// File: rtl/bp_pht_ctrl_if.sv
// Bundle of the lookup, update and RAM-port signals of the PHT sequencing controller.
// The slave side is the controller; the master side is fetch/execute plus the RAM.
interface bp_pht_ctrl_if #(
   parameter int AW = 8
);
   logic          lk_valid;
   logic [AW-1:0] lk_addr;
   logic          lk_ready;
   logic          lk_rvalid;
   logic          lk_taken;
   logic          up_valid;
   logic [AW-1:0] up_addr;
   logic          up_taken;
   logic          up_ready;
   logic          init_busy;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_wdata;
   logic [1:0]    mem_rdata;

   modport master (
      output lk_valid, lk_addr, up_valid, up_addr, up_taken, mem_rdata,
      input  lk_ready, lk_rvalid, lk_taken, up_ready, init_busy,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  lk_valid, lk_addr, up_valid, up_addr, up_taken, mem_rdata,
      output lk_ready, lk_rvalid, lk_taken, up_ready, init_busy,
      output mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/bp_pht_ctrl.sv
// Single-port 2-bit PHT controller: init sweep, fetch lookups, and FIFO-buffered
// read-modify-write training updates arbitrated onto one RAM port.
module bp_pht_ctrl #(
   parameter int AW     = 8,
   parameter int QDEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   bp_pht_ctrl_if.slave  bus
);

   localparam int            QW       = $clog2(QDEPTH);
   localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
   localparam logic [QW:0]   Q_FULL   = (QW+1)'(QDEPTH);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPD_WR = 2'd2
   } state_t;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      sat_inc = (c == 2'b11) ? 2'b11 : (c + 2'b01);
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      sat_dec = (c == 2'b00) ? 2'b00 : (c - 2'b01);
   endfunction

   state_t        state_r;
   state_t        state_nxt_s;
   logic [AW-1:0] init_cnt_r;
   logic          lk_rvalid_r;

   logic [AW-1:0] fifo_addr_r  [QDEPTH];
   logic          fifo_taken_r [QDEPTH];
   logic [QW-1:0] wr_ptr_r;
   logic [QW-1:0] rd_ptr_r;
   logic [QW:0]   count_r;

   logic          full_s;
   logic          empty_s;
   logic          up_ready_s;
   logic          push_s;
   logic          pop_s;
   logic          lk_grant_s;
   logic [AW-1:0] head_addr_s;
   logic          head_taken_s;
   logic          mem_en_s;
   logic          mem_we_s;
   logic [AW-1:0] mem_addr_s;
   logic [1:0]    mem_wdata_s;

   assign full_s       = (count_r == Q_FULL);
   assign empty_s      = (count_r == {(QW+1){1'b0}});
   assign up_ready_s   = !full_s && !rst;
   assign push_s       = bus.up_valid && up_ready_s;
   assign head_addr_s  = fifo_addr_r[rd_ptr_r];
   assign head_taken_s = fifo_taken_r[rd_ptr_r];

   // Port arbitration and next state; a full FIFO forces the update ahead of lookups.
   always_comb begin
      state_nxt_s = state_r;
      lk_grant_s  = 1'b0;
      pop_s       = 1'b0;
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = {AW{1'b0}};
      mem_wdata_s = 2'b00;
      if (rst) begin
         state_nxt_s = ST_INIT;
      end else begin
         case (state_r)
            ST_INIT: begin
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = init_cnt_r;
               mem_wdata_s = 2'b01;
               if (init_cnt_r == LAST_IDX) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_INIT;
               end
            end
            ST_IDLE: begin
               if (bus.lk_valid && !full_s) begin
                  lk_grant_s = 1'b1;
                  mem_en_s   = 1'b1;
                  mem_addr_s = bus.lk_addr;
               end else if (!empty_s) begin
                  mem_en_s    = 1'b1;
                  mem_addr_s  = head_addr_s;
                  state_nxt_s = ST_UPD_WR;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_UPD_WR: begin
               mem_en_s    = 1'b1;
               mem_we_s    = 1'b1;
               mem_addr_s  = head_addr_s;
               mem_wdata_s = head_taken_s ? sat_inc(bus.mem_rdata) : sat_dec(bus.mem_rdata);
               pop_s       = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_INIT;
            end
         endcase
      end
   end

   // State register, sweep counter and the one-cycle lookup result flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_INIT;
         init_cnt_r  <= {AW{1'b0}};
         lk_rvalid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         lk_rvalid_r <= lk_grant_s;
         if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + AW'(1'b1);
         end else begin
            init_cnt_r <= init_cnt_r;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since QDEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {QW{1'b0}};
         rd_ptr_r <= {QW{1'b0}};
         count_r  <= {(QW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + QW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + QW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (QW+1)'(1'b1);
            2'b01:   count_r <= count_r - (QW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO payload storage; contents are don't-care until pushed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r]  <= bus.up_addr;
         fifo_taken_r[wr_ptr_r] <= bus.up_taken;
      end
   end

   assign bus.lk_ready  = lk_grant_s;
   assign bus.lk_rvalid = lk_rvalid_r;
   assign bus.lk_taken  = lk_rvalid_r & bus.mem_rdata[1];
   assign bus.up_ready  = up_ready_s;
   assign bus.init_busy = (state_r == ST_INIT) || rst;
   assign bus.mem_en    = mem_en_s;
   assign bus.mem_we    = mem_we_s;
   assign bus.mem_addr  = mem_addr_s;
   assign bus.mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_bp_pht_ctrl.sv
// Self-checking bench for bp_pht_ctrl: RAM model, table-level reference scoreboard
// sampled on negedge, directed scenarios and a randomized traffic phase.
module tb_bp_pht_ctrl;

   localparam int AW     = 8;
   localparam int QDEPTH = 4;
   localparam int DEPTH  = 1 << AW;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          taken;
   } upd_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bp_pht_ctrl_if #(.AW(AW)) bus ();
   bp_pht_ctrl #(.AW(AW), .QDEPTH(QDEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= ram[bus.mem_addr];
      end
   end

   int          n_cmp = 0;
   int          n_err = 0;
   upd_t        exp_q [$];
   logic [AW+1:0] wr_log [$];
   int          ref_pht [DEPTH];
   int          init_idx;
   bit          lk_pend, prev_rd, prev_busy;
   logic        lk_exp;

   // Reference: table of counter values, queue of pending updates in push order.
   always @(negedge clk) begin : mon
      int   occ, v;
      bit   cur_rd, pend_n;
      logic exp_lkr, exp_en, exp_n;
      upd_t h;
      if (rst) begin
         n_cmp++;
         if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 ||
             bus.mem_wdata !== 2'b00 || bus.lk_ready !== 1'b0 || bus.up_ready !== 1'b0 ||
             bus.init_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mon_reset_outputs en=%b we=%b addr=%h wd=%b lkr=%b upr=%b busy=%b (want 0,0,0,0,0,0,1)",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.lk_ready, bus.up_ready, bus.init_busy);
         end
         exp_q.delete();
         init_idx  = 0;
         lk_pend   = 1'b0;
         prev_rd   = 1'b0;
         prev_busy = 1'b1;
      end else begin
         occ    = exp_q.size();
         cur_rd = 1'b0;
         pend_n = 1'b0;
         exp_n  = 1'b0;
         n_cmp++;
         if (bus.lk_rvalid !== lk_pend) begin
            n_err++; $display("FAIL mon_lk_rvalid got=%b want=%b", bus.lk_rvalid, lk_pend);
         end
         if (lk_pend) begin
            n_cmp++;
            if (bus.lk_taken !== lk_exp) begin
               n_err++; $display("FAIL mon_lk_taken got=%b want=%b", bus.lk_taken, lk_exp);
            end
         end
         if (prev_busy && !bus.init_busy) begin
            n_cmp++;
            if (init_idx != DEPTH) begin
               n_err++; $display("FAIL mon_init_len got=%0d want=%0d", init_idx, DEPTH);
            end
         end
         n_cmp++;
         if (bus.up_ready !== (occ < QDEPTH)) begin
            n_err++; $display("FAIL mon_up_ready got=%b occ=%0d", bus.up_ready, occ);
         end
         exp_lkr = bus.lk_valid && !bus.init_busy && (occ < QDEPTH) && !prev_rd;
         n_cmp++;
         if (bus.lk_ready !== exp_lkr) begin
            n_err++; $display("FAIL mon_lk_ready got=%b want=%b occ=%0d", bus.lk_ready, exp_lkr, occ);
         end
         exp_en = bus.init_busy || exp_lkr || prev_rd || (occ != 0);
         n_cmp++;
         if (bus.mem_en !== exp_en) begin
            n_err++; $display("FAIL mon_mem_en got=%b want=%b", bus.mem_en, exp_en);
         end
         if (bus.mem_en) begin
            if (bus.init_busy) begin
               n_cmp++;
               if (bus.mem_we !== 1'b1 || bus.mem_addr !== init_idx[AW-1:0] || bus.mem_wdata !== 2'b01) begin
                  n_err++; $display("FAIL mon_init_write we=%b addr=%h wd=%b want 1,%h,01",
                                    bus.mem_we, bus.mem_addr, bus.mem_wdata, init_idx[AW-1:0]);
               end
               ref_pht[bus.mem_addr] = 1;
               init_idx++;
            end else if (prev_rd) begin
               n_cmp++;
               if (occ == 0) begin
                  n_err++; $display("FAIL mon_upd_write got=write want=no_pending_update");
               end else begin
                  h = exp_q.pop_front();
                  v = ref_pht[h.addr];
                  v = h.taken ? ((v < 3) ? v + 1 : 3) : ((v > 0) ? v - 1 : 0);
                  if (bus.mem_we !== 1'b1 || bus.mem_addr !== h.addr || bus.mem_wdata !== 2'(v)) begin
                     n_err++; $display("FAIL mon_upd_write we=%b addr=%h wd=%b want 1,%h,%0d",
                                       bus.mem_we, bus.mem_addr, bus.mem_wdata, h.addr, v);
                  end
                  ref_pht[h.addr] = v;
                  wr_log.push_back({bus.mem_addr, bus.mem_wdata});
               end
            end else if (bus.lk_ready) begin
               n_cmp++;
               if (bus.mem_we !== 1'b0 || bus.mem_addr !== bus.lk_addr) begin
                  n_err++; $display("FAIL mon_lk_read we=%b addr=%h want 0,%h", bus.mem_we, bus.mem_addr, bus.lk_addr);
               end
               pend_n = 1'b1;
               exp_n  = (ref_pht[bus.lk_addr] >= 2) ? 1'b1 : 1'b0;
            end else begin
               cur_rd = 1'b1;
               n_cmp++;
               if (occ == 0) begin
                  n_err++; $display("FAIL mon_upd_read got=read want=idle");
               end else if (bus.mem_we !== 1'b0 || bus.mem_addr !== exp_q[0].addr) begin
                  n_err++; $display("FAIL mon_upd_read we=%b addr=%h want 0,%h", bus.mem_we, bus.mem_addr, exp_q[0].addr);
               end
            end
         end
         if (bus.up_valid && bus.up_ready) exp_q.push_back({bus.up_addr, bus.up_taken});
         prev_rd   = cur_rd;
         lk_pend   = pend_n;
         lk_exp    = exp_n;
         prev_busy = bus.init_busy;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_up(input logic [AW-1:0] a, input logic t, output bit ok);
      bus.up_valid = 1'b1; bus.up_addr = a; bus.up_taken = t; ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk); ok = bus.up_ready;
         tick();
      end
      bus.up_valid = 1'b0;
   endtask

   task automatic lookup(input logic [AW-1:0] a, output bit acc, output logic rv, output logic tk);
      bus.lk_valid = 1'b1; bus.lk_addr = a; acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk); acc = bus.lk_ready;
         tick();
      end
      bus.lk_valid = 1'b0;
      @(negedge clk); rv = bus.lk_rvalid; tk = bus.lk_taken;
      tick();
   endtask

   task automatic drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) begin ok = 1'b1; break; end
         tick();
      end
      tick(); tick();
   endtask

   task automatic wait_init(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!bus.init_busy) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.init_busy !== 1'b1 || bus.mem_en !== 1'b0 || bus.lk_ready !== 1'b0 || bus.up_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_state busy=%b en=%b lkr=%b upr=%b want 1,0,0,0",
                           bus.init_busy, bus.mem_en, bus.lk_ready, bus.up_ready);
      end
      tick();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!bus.init_busy) break;
         if (bus.mem_en && bus.mem_we && bus.mem_wdata == 2'b01 && bus.mem_addr == cnt[AW-1:0]) cnt++;
      end
      n_cmp++;
      if (cnt != DEPTH || bus.init_busy !== 1'b0) begin
         n_err++; $display("FAIL init_sweep writes=%0d busy=%b want %0d,0", cnt, bus.init_busy, DEPTH);
      end
      tick();
   endtask

   task automatic test_init_lookup();
      bus.lk_valid = 1'b1; bus.lk_addr = 8'h3C;
      @(negedge clk);
      n_cmp++;
      if (bus.lk_ready !== 1'b1) begin
         n_err++; $display("FAIL init_lookup_ready got=%b want=1", bus.lk_ready);
      end
      tick();
      bus.lk_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.lk_rvalid !== 1'b1 || bus.lk_taken !== 1'b0) begin
         n_err++; $display("FAIL init_lookup_result rv=%b tk=%b want 1,0", bus.lk_rvalid, bus.lk_taken);
      end
      tick();
   endtask

   task automatic test_training();
      bit ok1, ok2, okd, acc;
      logic rv, tk;
      wr_log.delete();
      push_up(8'h10, 1'b1, ok1);
      push_up(8'h10, 1'b1, ok2);
      drain(okd);
      n_cmp++;
      if (!(ok1 && ok2 && okd) || wr_log.size() != 2) begin
         n_err++; $display("FAIL train_count writes=%0d ok=%b%b%b want 2,111", wr_log.size(), ok1, ok2, okd);
      end else if (wr_log[0] !== {8'h10, 2'b10} || wr_log[1] !== {8'h10, 2'b11}) begin
         n_err++; $display("FAIL train_values got=%h,%h want=%h,%h", wr_log[0], wr_log[1], {8'h10, 2'b10}, {8'h10, 2'b11});
      end
      lookup(8'h10, acc, rv, tk);
      n_cmp++;
      if (!acc || rv !== 1'b1 || tk !== 1'b1) begin
         n_err++; $display("FAIL train_lookup acc=%b rv=%b tk=%b want 1,1,1", acc, rv, tk);
      end
      wr_log.delete();
      push_up(8'h10, 1'b1, ok1);
      drain(okd);
      n_cmp++;
      if (wr_log.size() != 1 || wr_log[0] !== {8'h10, 2'b11}) begin
         n_err++; $display("FAIL train_saturate writes=%0d first=%h want 1,%h", wr_log.size(),
                           (wr_log.size() > 0) ? wr_log[0] : 10'h0, {8'h10, 2'b11});
      end
   endtask

   task automatic test_dec_saturate();
      bit ok1, ok2, okd, acc;
      logic rv, tk;
      wr_log.delete();
      push_up(8'h22, 1'b0, ok1);
      push_up(8'h22, 1'b0, ok2);
      drain(okd);
      n_cmp++;
      if (!(ok1 && ok2 && okd) || wr_log.size() != 2) begin
         n_err++; $display("FAIL dec_count writes=%0d want 2", wr_log.size());
      end else if (wr_log[0] !== {8'h22, 2'b00} || wr_log[1] !== {8'h22, 2'b00}) begin
         n_err++; $display("FAIL dec_values got=%h,%h want=%h,%h", wr_log[0], wr_log[1], {8'h22, 2'b00}, {8'h22, 2'b00});
      end
      lookup(8'h22, acc, rv, tk);
      n_cmp++;
      if (!acc || rv !== 1'b1 || tk !== 1'b0) begin
         n_err++; $display("FAIL dec_lookup acc=%b rv=%b tk=%b want 1,1,0", acc, rv, tk);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [5];
      logic          want  [5];
      logic          rdy [5], rv [5], tk [5];
      addrs = '{8'h10, 8'h22, 8'h3C, 8'h10, 8'h22};
      want  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin bus.lk_valid = 1'b1; bus.lk_addr = addrs[i]; end
         else       bus.lk_valid = 1'b0;
         @(negedge clk);
         if (i < 5) rdy[i] = bus.lk_ready;
         if (i > 0) begin rv[i-1] = bus.lk_rvalid; tk[i-1] = bus.lk_taken; end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (rdy[i] !== 1'b1 || rv[i] !== 1'b1 || tk[i] !== want[i]) begin
            n_err++; $display("FAIL b2b_%0d rdy=%b rv=%b tk=%b want 1,1,%b", i, rdy[i], rv[i], tk[i], want[i]);
         end
      end
   endtask

   task automatic test_arbitration();
      logic [3:0] seq;
      bit okd;
      wr_log.delete();
      bus.lk_valid = 1'b1; bus.lk_addr = 8'h40;
      for (int k = 0; k < 4; k++) begin
         bus.up_valid = 1'b1; bus.up_addr = 8'h60 + 8'(k); bus.up_taken = k[0];
         @(negedge clk);
         n_cmp++;
         if (bus.up_ready !== 1'b1 || bus.lk_ready !== 1'b1) begin
            n_err++; $display("FAIL arb_fill_%0d upr=%b lkr=%b want 1,1", k, bus.up_ready, bus.lk_ready);
         end
         tick();
      end
      bus.up_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk); seq[j] = bus.lk_ready;
         tick();
      end
      n_cmp++;
      if (seq !== 4'b1100) begin
         n_err++; $display("FAIL arb_full_seq got=%b want=1100", seq);
      end
      bus.lk_valid = 1'b0;
      drain(okd);
      n_cmp++;
      if (!okd || wr_log.size() != 4) begin
         n_err++; $display("FAIL arb_retire writes=%0d want 4", wr_log.size());
      end else if (wr_log[0] !== {8'h60, 2'b00} || wr_log[1] !== {8'h61, 2'b10} ||
                   wr_log[2] !== {8'h62, 2'b00} || wr_log[3] !== {8'h63, 2'b10}) begin
         n_err++; $display("FAIL arb_values got=%h,%h,%h,%h want=180,186,188,18e", wr_log[0], wr_log[1], wr_log[2], wr_log[3]);
      end
   endtask

   task automatic test_init_updates();
      bit oki, okd;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_log.delete();
      for (int c = 0; c < 10; c++) begin
         bus.up_valid = (c == 2 || c == 5 || c == 8);
         bus.up_addr  = (c == 5) ? 8'h71 : 8'h70;
         bus.up_taken = (c != 5);
         @(negedge clk);
         if (bus.up_valid) begin
            n_cmp++;
            if (bus.up_ready !== 1'b1 || bus.init_busy !== 1'b1) begin
               n_err++; $display("FAIL init_upd_accept_%0d upr=%b busy=%b want 1,1", c, bus.up_ready, bus.init_busy);
            end
         end
         tick();
      end
      bus.up_valid = 1'b0;
      wait_init(oki);
      n_cmp++;
      if (!oki || wr_log.size() != 0) begin
         n_err++; $display("FAIL init_upd_hold done=%b writes=%0d want 1,0", oki, wr_log.size());
      end
      drain(okd);
      n_cmp++;
      if (!okd || wr_log.size() != 3) begin
         n_err++; $display("FAIL init_upd_count writes=%0d want 3", wr_log.size());
      end else if (wr_log[0] !== {8'h70, 2'b10} || wr_log[1] !== {8'h71, 2'b00} || wr_log[2] !== {8'h70, 2'b11}) begin
         n_err++; $display("FAIL init_upd_order got=%h,%h,%h want=1c2,1c4,1c3", wr_log[0], wr_log[1], wr_log[2]);
      end
   endtask

   task automatic test_mid_reset();
      bit oki, okd, acc;
      logic rv, tk;
      wr_log.delete();
      bus.up_valid = 1'b1; bus.up_addr = 8'h90; bus.up_taken = 1'b1;
      tick();
      bus.up_addr = 8'h91;
      @(negedge clk);
      n_cmp++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h90) begin
         n_err++; $display("FAIL midrst_read en=%b we=%b addr=%h want 1,0,90", bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      tick();
      bus.up_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0) begin
         n_err++; $display("FAIL midrst_no_write en=%b we=%b want 0,0", bus.mem_en, bus.mem_we);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.lk_rvalid !== 1'b0 || bus.init_busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h00) begin
         n_err++; $display("FAIL midrst_restart rv=%b busy=%b we=%b addr=%h want 0,1,1,00",
                           bus.lk_rvalid, bus.init_busy, bus.mem_we, bus.mem_addr);
      end
      tick();
      wait_init(oki);
      drain(okd);
      n_cmp++;
      if (!oki || !okd || wr_log.size() != 0) begin
         n_err++; $display("FAIL midrst_flush done=%b writes=%0d want 1,0", oki, wr_log.size());
      end
      lookup(8'h90, acc, rv, tk);
      n_cmp++;
      if (!acc || rv !== 1'b1 || tk !== 1'b0) begin
         n_err++; $display("FAIL midrst_lookup acc=%b rv=%b tk=%b want 1,1,0", acc, rv, tk);
      end
   endtask

   task automatic test_random();
      bit okd;
      for (int i = 0; i < 1500; i++) begin
         bus.lk_valid = ($urandom_range(0, 9) < 7);
         bus.lk_addr  = {4'h8, 4'($urandom_range(0, 15))};
         bus.up_valid = ($urandom_range(0, 9) < 6);
         bus.up_addr  = {4'h8, 4'($urandom_range(0, 15))};
         bus.up_taken = 1'($urandom_range(0, 1));
         tick();
      end
      bus.lk_valid = 1'b0;
      bus.up_valid = 1'b0;
      drain(okd);
      n_cmp++;
      if (!okd) begin
         n_err++; $display("FAIL random_drain pending=%0d want 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.lk_valid = 1'b0; bus.lk_addr = 8'h00;
      bus.up_valid = 1'b0; bus.up_addr = 8'h00; bus.up_taken = 1'b0;
      test_reset();
      test_init_lookup();
      test_training();
      test_dec_saturate();
      test_back_to_back();
      test_arbitration();
      test_init_updates();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
